// File: rtl/pc_address_unit_pkg.sv
// Shared control codes for the program-counter/address unit and the decoder that drives it,
// plus the PC next-value helper used once the vector fetch is complete.
package pc_address_unit_pkg;

   localparam logic [2:0] PC_HOLD   = 3'b000;
   localparam logic [2:0] PC_LD_LO  = 3'b001;
   localparam logic [2:0] PC_LD_HI  = 3'b010;
   localparam logic [2:0] PC_INC    = 3'b011;
   localparam logic [2:0] PC_JMP    = 3'b100;

   localparam logic [1:0] ADR_SEL_PC  = 2'd0;
   localparam logic [1:0] ADR_SEL_MEM = 2'd1;
   localparam logic [1:0] ADR_SEL_ALU = 2'd2;

   localparam logic [15:0] VECTOR_RESET = 16'hFFFC;

   typedef enum logic [1:0] {
      VEC_LO = 2'd0,
      VEC_HI = 2'd1,
      RUN    = 2'd2
   } vec_state_e;

   // Codes 101/110/111 fall into the hold arm on purpose.
   function automatic logic [15:0] pc_next(input logic [15:0] pc,
                                           input logic [2:0]  op,
                                           input logic [7:0]  din,
                                           input logic [15:0] jmp);
      logic [15:0] nxt;
      nxt = pc;
      case (op)
         PC_INC:   nxt = pc + 16'd1;
         PC_LD_LO: nxt = {pc[15:8], din};
         PC_LD_HI: nxt = {din, pc[7:0]};
         PC_JMP:   nxt = jmp;
         default:  nxt = pc;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/pc_address_unit.sv
// Program counter owner and address-bus driver: fetches the reset vector, then follows
// the decoder's pc_enable / address_select controls.
module pc_address_unit
   import pc_address_unit_pkg::*;
#(
   parameter logic [15:0] RESET_VECTOR = VECTOR_RESET,
   parameter bit          SKIP_VECTOR  = 1'b0,
   parameter logic [15:0] RESET_PC     = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_enable,
   input  logic [2:0]  pc_enable,
   input  logic [1:0]  address_select,
   input  logic [15:0] memory_address,
   input  logic [7:0]  alu_result,
   input  logic [7:0]  data_in,
   output logic [15:0] address_out,
   output logic [15:0] pc_out,
   output logic        ready
);

   localparam vec_state_e  RST_STATE = SKIP_VECTOR ? RUN : VEC_LO;
   localparam logic [15:0] VEC_HI_ADDR = RESET_VECTOR + 16'd1;

   vec_state_e  state_q;
   logic [15:0] pc_q;
   logic [15:0] pc_d;
   logic        ready_q;

   assign pc_d = pc_next(pc_q, pc_enable, data_in, memory_address);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_STATE;
         pc_q    <= RESET_PC;
         ready_q <= SKIP_VECTOR;
      end else if (clk_enable) begin
         case (state_q)
            VEC_LO: begin
               pc_q[7:0] <= data_in;
               state_q   <= VEC_HI;
            end
            VEC_HI: begin
               pc_q[15:8] <= data_in;
               state_q    <= RUN;
               ready_q    <= 1'b1;
            end
            RUN: begin
               pc_q <= pc_d;
            end
            default: begin
               state_q <= RST_STATE;
               pc_q    <= RESET_PC;
               ready_q <= SKIP_VECTOR;
            end
         endcase
      end
   end

   // Bus reflects the registered PC, so an increment shows the pre-increment value this cycle.
   always_comb begin
      address_out = pc_q;
      case (state_q)
         VEC_LO: address_out = RESET_VECTOR;
         VEC_HI: address_out = VEC_HI_ADDR;
         default: begin
            case (address_select)
               ADR_SEL_MEM: address_out = memory_address;
               ADR_SEL_ALU: address_out = {8'h00, alu_result};
               default:     address_out = pc_q;
            endcase
         end
      endcase
   end

   assign pc_out = pc_q;
   assign ready  = ready_q;

endmodule

// File: tb/tb_pc_address_unit.sv
// Directed and randomized checks of pc_address_unit against a byte-arithmetic reference model.
module tb_pc_address_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clk_enable;
   logic [2:0]  pc_enable;
   logic [1:0]  address_select;
   logic [15:0] memory_address;
   logic [7:0]  alu_result;
   logic [7:0]  data_in;
   logic [15:0] address_out, pc_out;
   logic        ready;
   logic [15:0] s_address_out, s_pc_out;
   logic        s_ready;

   int checks = 0;
   int errors = 0;

   // Reference model: PC as an integer, fetch progress as number of vector bytes taken.
   int m_pc;
   int m_bytes;

   always #5 clk = ~clk;

   pc_address_unit dut (
      .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .pc_enable(pc_enable),
      .address_select(address_select), .memory_address(memory_address),
      .alu_result(alu_result), .data_in(data_in),
      .address_out(address_out), .pc_out(pc_out), .ready(ready)
   );

   pc_address_unit #(.SKIP_VECTOR(1'b1), .RESET_PC(16'hABCD)) dut_skip (
      .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .pc_enable(pc_enable),
      .address_select(address_select), .memory_address(memory_address),
      .alu_result(alu_result), .data_in(data_in),
      .address_out(s_address_out), .pc_out(s_pc_out), .ready(s_ready)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_addr();
      if (m_bytes == 0) return 16'hFFFC;
      if (m_bytes == 1) return 16'hFFFD;
      case (address_select)
         2'd1:    return memory_address;
         2'd2:    return 16'(alu_result);
         default: return 16'(m_pc);
      endcase
   endfunction

   task automatic model_edge();
      if (!(rst_n && clk_enable)) return;
      if (m_bytes == 0) begin
         m_pc = (m_pc / 256) * 256 + int'(data_in);
         m_bytes = 1;
      end else if (m_bytes == 1) begin
         m_pc = int'(data_in) * 256 + (m_pc % 256);
         m_bytes = 2;
      end else begin
         case (pc_enable)
            3'b011:  m_pc = (m_pc + 1) % 65536;
            3'b001:  m_pc = (m_pc / 256) * 256 + int'(data_in);
            3'b010:  m_pc = int'(data_in) * 256 + (m_pc % 256);
            3'b100:  m_pc = int'(memory_address);
            default: m_pc = m_pc;
         endcase
      end
   endtask

   function automatic logic [15:0] exp_ready();
      return (m_bytes == 2) ? 16'd1 : 16'd0;
   endfunction

   // One clock: inputs already driven; check bus before the edge, state after it.
   task automatic cycle(input string tag);
      #1;
      check({tag, ".addr"}, address_out, exp_addr());
      @(posedge clk);
      model_edge();
      #1;
      check({tag, ".pc"}, pc_out, 16'(m_pc));
      check({tag, ".ready"}, 16'(ready), exp_ready());
   endtask

   task automatic reset_now(input string tag);
      rst_n = 1'b0;
      m_pc = 0;
      m_bytes = 0;
      #1;
      check({tag, ".pc"}, pc_out, 16'h0000);
      check({tag, ".ready"}, 16'(ready), 16'd0);
      check({tag, ".addr"}, address_out, 16'hFFFC);
      check({tag, ".skip_pc"}, s_pc_out, 16'hABCD);
      check({tag, ".skip_ready"}, 16'(s_ready), 16'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      clk_enable = 1'b1;
      pc_enable = 3'b000;
      address_select = 2'd0;
      memory_address = 16'h0000;
      alu_result = 8'h00;
      data_in = 8'h00;
      #12;
      reset_now("reset");
      rst_n = 1'b1;

      // Vector fetch
      data_in = 8'h34;
      cycle("vec_lo");
      data_in = 8'h12;
      cycle("vec_hi");
      check("vec.pc1234", pc_out, 16'h1234);
      check("skip.pc_hold", s_pc_out, 16'hABCD);
      check("skip.ready", 16'(s_ready), 16'd1);
      check("skip.addr", s_address_out, 16'hABCD);

      // Increment three times; first cycle bus shows 1234
      pc_enable = 3'b011;
      cycle("inc1");
      cycle("inc2");
      cycle("inc3");
      check("inc.pc1237", pc_out, 16'h1237);

      // Wrap FFFF -> 0000 with a disabled cycle in between
      pc_enable = 3'b100;
      memory_address = 16'hFFFF;
      cycle("jmp_ffff");
      pc_enable = 3'b011;
      clk_enable = 1'b0;
      cycle("hold_ce0");
      clk_enable = 1'b1;
      cycle("wrap");
      check("wrap.pc0000", pc_out, 16'h0000);

      // Address select variants
      pc_enable = 3'b000;
      address_select = 2'd1;
      memory_address = 16'h00A5;
      cycle("sel_mem");
      address_select = 2'd2;
      alu_result = 8'hF0;
      cycle("sel_alu");
      address_select = 2'd3;
      cycle("sel_pc3");

      // Jump, byte loads, unlisted code
      address_select = 2'd0;
      pc_enable = 3'b100;
      memory_address = 16'hC000;
      cycle("jmp_c000");
      pc_enable = 3'b001;
      data_in = 8'h7F;
      cycle("ld_lo");
      check("ld_lo.c07f", pc_out, 16'hC07F);
      pc_enable = 3'b010;
      data_in = 8'h55;
      cycle("ld_hi");
      pc_enable = 3'b110;
      cycle("unlisted");

      // Reset during VEC_HI, then fetch restarts at FFFC
      pc_enable = 3'b000;
      reset_now("rst_pre");
      rst_n = 1'b1;
      data_in = 8'hAA;
      cycle("refetch_lo");
      #2;
      check("vec_hi.addr", address_out, 16'hFFFD);
      reset_now("rst_mid");
      rst_n = 1'b1;
      data_in = 8'h00;
      cycle("restart_lo");
      data_in = 8'h80;
      cycle("restart_hi");

      // Randomized run with occasional disabled cycles and resets
      for (int i = 0; i < 400; i++) begin
         clk_enable = ($urandom_range(3) != 0);
         pc_enable = 3'($urandom_range(7));
         address_select = 2'($urandom_range(3));
         memory_address = 16'($urandom);
         alu_result = 8'($urandom);
         data_in = 8'($urandom);
         if ($urandom_range(49) == 0) begin
            reset_now("rnd_rst");
            rst_n = 1'b1;
         end
         cycle("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
